// File: rtl/storebuf_pkg.sv
// Shared types and helpers for the store buffer: access-size encodings,
// the per-entry record, and the byte-enable / data-mask lookups.
`ifndef VA_BITS
`define VA_BITS 48
`endif
`ifndef VA_MSB
`define VA_MSB (`VA_BITS-1)
`endif

package storebuf_pkg;

   localparam int QW_BITS = `VA_BITS - 3;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_WORD = 2'd1,
      SZ_LONG = 2'd2,
      SZ_QUAD = 2'd3
   } op_size_t;

   // Entries hold the quadword-aligned address only; the low three bits are implied zero.
   typedef struct packed {
      logic               vld;
      logic [7:0]         be;
      logic [63:0]        data;
      logic [QW_BITS-1:0] addr;
   } entry_t;

   function automatic logic [7:0] size_be(op_size_t sz);
      logic [7:0] be;
      case (sz)
         SZ_BYTE: be = 8'h01;
         SZ_WORD: be = 8'h03;
         SZ_LONG: be = 8'h0F;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

   function automatic logic [63:0] size_mask(op_size_t sz);
      logic [63:0] m;
      case (sz)
         SZ_BYTE: m = 64'h0000_0000_0000_00FF;
         SZ_WORD: m = 64'h0000_0000_0000_FFFF;
         SZ_LONG: m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/storebuf_if.sv
// E0 issue port, E1 replay flag and the head-of-buffer channel toward the D$.
`ifndef VA_BITS
`define VA_BITS 48
`endif

interface storebuf_if;
   logic                store_e0;
   logic                load_e0;
   logic [1:0]          op_size_e0;
   logic [`VA_BITS-1:0] va_e0;
   logic [63:0]         store_data_e0;
   logic                stb_fail_e1;
   logic                rtr_st_vld_xx;
   logic [7:0]          rtr_st_be_xx;
   logic [63:0]         rtr_st_data_xx;
   logic [`VA_BITS-1:0] rtr_st_addr_xx;
   logic                rtr_st_ack_xx;

   modport master (
      output store_e0, load_e0, op_size_e0, va_e0, store_data_e0, rtr_st_ack_xx,
      input  stb_fail_e1, rtr_st_vld_xx, rtr_st_be_xx, rtr_st_data_xx, rtr_st_addr_xx
   );

   modport slave (
      input  store_e0, load_e0, op_size_e0, va_e0, store_data_e0, rtr_st_ack_xx,
      output stb_fail_e1, rtr_st_vld_xx, rtr_st_be_xx, rtr_st_data_xx, rtr_st_addr_xx
   );
endinterface

// File: rtl/storebuf_align.sv
// Lane alignment of an e0 access: byte enables and data shifted into the
// quadword lanes selected by va[2:0]; anything shifted past lane 7 is dropped.
module storebuf_align
   import storebuf_pkg::*;
(
   input  logic [1:0]  op_size,
   input  logic [2:0]  va_lo,
   input  logic [63:0] data_in,
   output logic [7:0]  be,
   output logic [63:0] data_al
);

   op_size_t sz;

   always_comb begin
      sz      = op_size_t'(op_size);
      be      = size_be(sz) << va_lo;
      data_al = (data_in & size_mask(sz)) << {va_lo, 3'b000};
   end

endmodule

// File: rtl/storebuf_q.sv
// Circular store buffer with youngest-entry coalescing, full-drop replay and
// load-vs-store overlap replay. The head entry is presented to the D$ directly.
`ifndef VA_BITS
`define VA_BITS 48
`endif
`ifndef VA_MSB
`define VA_MSB (`VA_BITS-1)
`endif

module storebuf_q
   import storebuf_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int COALESCE = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   storebuf_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   entry_t             ent_q [DEPTH];
   entry_t             ent_d [DEPTH];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic               fail_q, fail_d;

   logic [7:0]         new_be;
   logic [63:0]        new_data;
   logic [QW_BITS-1:0] new_qw;
   logic [PW-1:0]      young;
   entry_t             head_ent;
   logic               pop, coalesce, has_room, alloc, drop, ld_hit;

   storebuf_align u_align (
      .op_size (bus.op_size_e0),
      .va_lo   (bus.va_e0[2:0]),
      .data_in (bus.store_data_e0),
      .be      (new_be),
      .data_al (new_data)
   );

   assign new_qw   = bus.va_e0[`VA_MSB:3];
   assign head_ent = ent_q[head_q];
   assign young    = tail_q - PW'(1);

   assign bus.rtr_st_vld_xx  = head_ent.vld;
   assign bus.rtr_st_be_xx   = head_ent.be;
   assign bus.rtr_st_data_xx = head_ent.data;
   assign bus.rtr_st_addr_xx = {head_ent.addr, 3'b000};
   assign bus.stb_fail_e1    = fail_q;

   assign pop = bus.rtr_st_ack_xx & head_ent.vld;

   // count>=2 keeps the merge target away from the head, which may be in flight to the D$.
   assign coalesce = (COALESCE != 0) && bus.store_e0 && (count_q >= CW'(2)) &&
                     ent_q[young].vld && (ent_q[young].addr == new_qw);
   assign has_room = (count_q < DEPTH_C) || pop;
   assign alloc    = bus.store_e0 && !coalesce && has_room;
   assign drop     = bus.store_e0 && !coalesce && !has_room;

   // A head being acked this cycle is still checked: its write has not landed yet.
   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].vld && (ent_q[i].addr == new_qw) && |(ent_q[i].be & new_be))
            ld_hit = 1'b1;
      end
   end

   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(alloc) - CW'(pop);
      fail_d  = drop | (bus.load_e0 & ld_hit);

      if (pop) begin
         ent_d[head_q].vld = 1'b0;
         head_d            = head_q + PW'(1);
      end

      if (coalesce) begin
         ent_d[young].be = ent_q[young].be | new_be;
         for (int b = 0; b < 8; b++) begin
            if (new_be[b])
               ent_d[young].data[8*b +: 8] = new_data[8*b +: 8];
         end
      end

      // Applied after the pop so a full-buffer alloc into the freed slot stays valid.
      if (alloc) begin
         ent_d[tail_q].vld  = 1'b1;
         ent_d[tail_q].be   = new_be;
         ent_d[tail_q].data = new_data;
         ent_d[tail_q].addr = new_qw;
         tail_d             = tail_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         fail_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fail_q  <= fail_d;
      end
   end

   // Only the valid bits are reset; payload storage simply holds.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_q[i].be   <= ent_d[i].be;
         ent_q[i].data <= ent_d[i].data;
         ent_q[i].addr <= ent_d[i].addr;
         if (!reset_n)
            ent_q[i].vld <= 1'b0;
         else
            ent_q[i].vld <= ent_d[i].vld;
      end
   end

endmodule

// File: doc/storebuf_q.md
STOREBUF_Q -- requirements
Module: storebuf_q

Interface
REQ-001 Parameter DEPTH, default 4, number of store-buffer entries (power of two, 2..16).
REQ-002 Parameter COALESCE, default 1, enables merging a store into the youngest entry.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 store_e0  in  1  store issue, stage e0.
REQ-006 load_e0  in  1  load issue, stage e0; checked against buffered stores.
REQ-007 op_size_e0  in  2  access size (byte/word/longword/quadword, package encodings).
REQ-008 va_e0  in  `VA_BITS  virtual address of the access.
REQ-009 store_data_e0  in  64  store data, right-justified.
REQ-010 stb_fail_e1  out  1  registered replay request, stage e1.
REQ-011 rtr_st_vld_xx  out  1  head entry valid toward D$.
REQ-012 rtr_st_be_xx  out  8  head byte enables.
REQ-013 rtr_st_data_xx  out  64  head data, lane-aligned.
REQ-014 rtr_st_addr_xx  out  `VA_BITS  head address, bits [2:0] forced to zero.
REQ-015 rtr_st_ack_xx  in  1  D$ accepted head this cycle; only legal when rtr_st_vld_xx=1.

Function
REQ-016 Byte-enable base: byte 0x01, word 0x03, longword 0x0F, quadword 0xFF; be = base << va[2:0], bits shifted past bit 7 are dropped.
REQ-017 Data mask: byte 8, word 16, longword 32, quadword 64 low bits; data = masked << (8*va[2:0]), truncated to 64.
REQ-018 Entries form a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-019 Head entry drives the rtr_st_* outputs combinationally from storage; rtr_st_ack_xx pops the head at the clock edge.
REQ-020 Coalesce: if COALESCE=1, store_e0=1, count>=2, and va[`VA_MSB:3] matches the youngest entry, merge into it: be |= new be, new bytes overwrite per lane; no allocation.
REQ-021 Coalescing into the head entry is forbidden (count==1 never coalesces); it allocates instead.
REQ-022 Otherwise a store allocates at tail when count<DEPTH, or when count==DEPTH and rtr_st_ack_xx=1 in the same cycle.
REQ-023 Store at count==DEPTH without ack is dropped and sets stb_fail_e1=1 next cycle.
REQ-024 Load conflict: load_e0=1 and any valid entry (including a head being acked this cycle) with equal va[`VA_MSB:3] and overlapping be sets stb_fail_e1=1 next cycle; no forwarding.
REQ-025 stb_fail_e1 is 0 in every other case; it is a one-cycle pulse per failing e0 op.
REQ-026 store_e0 and load_e0 are mutually exclusive; if both are asserted, store takes effect and the load check is still evaluated.
REQ-027 Simultaneous alloc and pop: count unchanged; both pointers advance.
REQ-028 Alloc into an empty buffer: rtr_st_vld_xx=1 on the following cycle (latency 1).

Reset
REQ-029 While reset_n=0 at a clock edge: all entry valid bits, count, head and tail clear; stb_fail_e1=0.
REQ-030 rtr_st_vld_xx=0 in the cycle after reset; buffered stores are discarded mid-operation; data/be/addr storage is not reset.

Structure
REQ-031 Package storebuf_pkg holds the op-size encodings, the DEPTH-independent entry struct (vld, be, data, addr), and the be/mask helper functions.
REQ-032 One combinational sub-module, storebuf_align, produces be and aligned data from op_size, va[2:0] and data; all state lives in storebuf_q.

Verification
REQ-033 Byte store, va=...05, data 0xAB -> head be=0x20, data=0x0000_AB00_0000_0000, addr[2:0]=0, vld one cycle later.
REQ-034 Fill 4 stores to distinct quadwords, no ack, 5th store -> stb_fail_e1=1 once; 5th with ack in the same cycle -> accepted, count stays 4.
REQ-035 Stores to 0x100 (longword) then 0x208 then 0x20C (longword) -> two entries at 0x100 and 0x208, second be=0xFF.
REQ-036 Buffered quadword at 0x40; load byte at 0x43 -> stb_fail_e1=1; load at 0x48 -> 0.
REQ-037 Longword store at va[2:0]=6 -> be=0xC0, upper two bytes dropped.
REQ-038 Reset asserted with 3 entries pending -> next cycle rtr_st_vld_xx=0, subsequent store appears as new head.
